// File: rtl/bidir_pkg.sv
// Shared types and helpers for the half-duplex bus sequencer.
// Used by bidir_cycle_timer and bidir_bus_sequencer.
package bidir_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        TX_DRIVE = 2'd1,
        RX_WAIT  = 2'd2,
        TURN     = 2'd3
    } state_e;

    localparam int DATA_W_DEF = 8;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

    // Width able to hold the value max_val itself.
    function automatic int cnt_w(input int max_val);
        int w;
        w = clog2(max_val + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/bidir_cycle_timer.sv
// Loadable down-counter; done_o is high while the count sits at zero.
// Load value N-1 to get done_o in the Nth enabled cycle after the load.
module bidir_cycle_timer #(
    parameter int W = 4
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         en_i,
    output logic         done_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (en_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign done_o = (cnt_q == '0);

endmodule

// File: rtl/bidir_bus_sequencer.sv
// Half-duplex bidirectional line sequencer: TX/RX arbitration with turnaround dead cycles.
// Optional RX inactivity abort enabled by defining BIDIR_RX_TIMEOUT_EN.
module bidir_bus_sequencer
    import bidir_pkg::*;
#(
    parameter int DATA_W      = DATA_W_DEF,
    parameter int TURN_CYCLES = 2,
    parameter int MAX_BURST   = 4,
    parameter int RX_TIMEOUT  = 64
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              tx_valid_i,
    input  logic [DATA_W-1:0] tx_data_i,
    output logic              tx_ready_o,
    input  logic              rx_req_i,
    input  logic              bus_strobe_i,
    input  logic [DATA_W-1:0] data_line_i,
    output logic              rx_valid_o,
    output logic [DATA_W-1:0] rx_data_o,
    output logic [DATA_W-1:0] data_line_o,
    output logic              tx_oe_o,
    output logic              busy_o,
    output logic              err_timeout_o
);

    localparam int BC_W  = cnt_w(MAX_BURST);
    localparam int TMR_W = cnt_w((TURN_CYCLES > RX_TIMEOUT) ? TURN_CYCLES : RX_TIMEOUT);

    state_e            state_q, state_d;
    logic [BC_W-1:0]   beat_q, beat_d;
    logic              last_rx_q, last_rx_d;
    logic [DATA_W-1:0] line_q, line_d;
    logic [DATA_W-1:0] rx_data_q, rx_data_d;
    logic              rx_valid_q, rx_valid_d;
    logic              err_q, err_d;

    logic tx_accept;
    logic turn_done;
    logic rx_timeout;

    assign tx_ready_o = (state_q == TX_DRIVE) && (beat_q < BC_W'(MAX_BURST));
    assign tx_accept  = tx_valid_i && tx_ready_o;

    always_comb begin
        state_d    = state_q;
        beat_d     = beat_q;
        last_rx_d  = last_rx_q;
        line_d     = line_q;
        rx_data_d  = rx_data_q;
        rx_valid_d = 1'b0;
        err_d      = 1'b0;
        case (state_q)
            IDLE: begin
                // On a tie the side that did not win last time gets the bus.
                if (tx_valid_i && (!rx_req_i || last_rx_q)) begin
                    state_d   = TX_DRIVE;
                    last_rx_d = 1'b0;
                end else if (rx_req_i) begin
                    state_d   = RX_WAIT;
                    last_rx_d = 1'b1;
                end
            end
            TX_DRIVE: begin
                if (tx_accept) begin
                    line_d = tx_data_i;
                    beat_d = beat_q + 1'b1;
                end else begin
                    state_d = TURN;
                    beat_d  = '0;
                end
            end
            RX_WAIT: begin
                if (bus_strobe_i) begin
                    rx_data_d  = data_line_i;
                    rx_valid_d = 1'b1;
                end
                if (!rx_req_i) begin
                    state_d = TURN;
                end else if (rx_timeout) begin
                    state_d = TURN;
                    err_d   = 1'b1;
                end
            end
            TURN: begin
                if (turn_done) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            beat_q     <= '0;
            last_rx_q  <= 1'b0;
            line_q     <= '0;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            beat_q     <= beat_d;
            last_rx_q  <= last_rx_d;
            line_q     <= line_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
            err_q      <= err_d;
        end
    end

    bidir_cycle_timer #(.W(TMR_W)) u_turn_timer (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .load_i     ((state_d == TURN) && (state_q != TURN)),
        .load_val_i (TMR_W'(TURN_CYCLES - 1)),
        .en_i       (state_q == TURN),
        .done_o     (turn_done)
    );

`ifdef BIDIR_RX_TIMEOUT_EN
    logic rxt_done;

    // Restarted on entry to RX_WAIT and by every peer strobe.
    bidir_cycle_timer #(.W(TMR_W)) u_rx_timer (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .load_i     (((state_d == RX_WAIT) && (state_q != RX_WAIT)) ||
                     ((state_q == RX_WAIT) && bus_strobe_i)),
        .load_val_i (TMR_W'(RX_TIMEOUT - 1)),
        .en_i       (state_q == RX_WAIT),
        .done_o     (rxt_done)
    );

    assign rx_timeout = rxt_done && !bus_strobe_i;
`else
    assign rx_timeout = 1'b0;
`endif

    assign tx_oe_o       = (state_q == TX_DRIVE);
    assign busy_o        = (state_q != IDLE);
    assign data_line_o   = line_q;
    assign rx_data_o     = rx_data_q;
    assign rx_valid_o    = rx_valid_q;
    assign err_timeout_o = err_q;

endmodule

// File: tb/tb_bidir_bus_sequencer.sv
// Directed bench for bidir_bus_sequencer with TX/RX byte scoreboards.
// Timeout expectations follow BIDIR_RX_TIMEOUT_EN as seen by this compile.
module tb_bidir_bus_sequencer;

    localparam int DW = 8;
`ifdef BIDIR_RX_TIMEOUT_EN
    localparam bit TMO = 1'b1;
`else
    localparam bit TMO = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_i = 1'b1;
    logic          tx_valid_i = 1'b0;
    logic [DW-1:0] tx_data_i = '0;
    logic          tx_ready_o;
    logic          rx_req_i = 1'b0;
    logic          bus_strobe_i = 1'b0;
    logic [DW-1:0] data_line_i = '0;
    logic          rx_valid_o;
    logic [DW-1:0] rx_data_o;
    logic [DW-1:0] data_line_o;
    logic          tx_oe_o;
    logic          busy_o;
    logic          err_timeout_o;

    int errors = 0;
    int checks = 0;
    logic [7:0] tx_q[$];
    logic [7:0] rx_q[$];

    bidir_bus_sequencer #(
        .DATA_W      (DW),
        .TURN_CYCLES (2),
        .MAX_BURST   (4),
        .RX_TIMEOUT  (8)
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst_i),
        .tx_valid_i    (tx_valid_i),
        .tx_data_i     (tx_data_i),
        .tx_ready_o    (tx_ready_o),
        .rx_req_i      (rx_req_i),
        .bus_strobe_i  (bus_strobe_i),
        .data_line_i   (data_line_i),
        .rx_valid_o    (rx_valid_o),
        .rx_data_o     (rx_data_o),
        .data_line_o   (data_line_o),
        .tx_oe_o       (tx_oe_o),
        .busy_o        (busy_o),
        .err_timeout_o (err_timeout_o)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic ck(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: inputs already driven, outputs checked at the falling edge.
    task automatic chk(input string tag, input logic e_oe, input logic e_rdy, input logic e_busy,
                       input logic e_rxv, input logic e_err, input bit pop_tx);
        logic [7:0] e;
        @(negedge clk);
        ck({tag, ".oe"},   8'(tx_oe_o),       8'(e_oe));
        ck({tag, ".rdy"},  8'(tx_ready_o),    8'(e_rdy));
        ck({tag, ".busy"}, 8'(busy_o),        8'(e_busy));
        ck({tag, ".rxv"},  8'(rx_valid_o),    8'(e_rxv));
        ck({tag, ".err"},  8'(err_timeout_o), 8'(e_err));
        if (pop_tx) begin
            e = (tx_q.size() > 0) ? tx_q.pop_front() : 8'hxx;
            ck({tag, ".line"}, data_line_o, e);
        end
        if (e_rxv) begin
            e = (rx_q.size() > 0) ? rx_q.pop_front() : 8'hxx;
            ck({tag, ".rxd"}, rx_data_o, e);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic txb(input string tag, input logic [7:0] d, input bit pop);
        tx_valid_i = 1'b1;
        tx_data_i  = d;
        tx_q.push_back(d);
        chk(tag, 1, 1, 1, 0, 0, pop);
    endtask

    task automatic turn2(input string tag);
        chk({tag, ".turn0"}, 0, 0, 1, 0, 0, 0);
        chk({tag, ".turn1"}, 0, 0, 1, 0, 0, 0);
    endtask

    task automatic do_reset();
        rst_i = 1'b1;
        tx_valid_i = 1'b0;
        rx_req_i = 1'b0;
        bus_strobe_i = 1'b0;
        @(posedge clk);
        #1;
        chk("rst", 0, 0, 0, 0, 0, 0);
        ck("rst.line", data_line_o, 8'h00);
        ck("rst.rxd", rx_data_o, 8'h00);
        rst_i = 1'b0;
    endtask

    initial begin
        do_reset();

        // 1: three beats, then release
        tx_valid_i = 1'b1; tx_data_i = 8'h3A;
        chk("t1.idle", 0, 0, 0, 0, 0, 0);
        txb("t1.b0", 8'h3A, 0);
        txb("t1.b1", 8'h55, 1);
        txb("t1.b2", 8'hFF, 1);
        tx_valid_i = 1'b0;
        chk("t1.last", 1, 1, 1, 0, 0, 1);
        turn2("t1");
        chk("t1.idle2", 0, 0, 0, 0, 0, 0);

        // 2: burst limit, hold cycle, re-grant
        tx_valid_i = 1'b1; tx_data_i = 8'h10;
        chk("t2.idle", 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) begin
            txb($sformatf("t2.b%0d", i), 8'(8'h10 + i), i != 0);
        end
        tx_data_i = 8'h14;
        chk("t2.hold", 1, 0, 1, 0, 0, 1);
        turn2("t2");
        chk("t2.regrant", 0, 0, 0, 0, 0, 0);
        txb("t2.b4", 8'h14, 0);
        txb("t2.b5", 8'h15, 1);
        tx_valid_i = 1'b0;
        chk("t2.last", 1, 1, 1, 0, 0, 1);
        turn2("t2b");
        chk("t2.idle2", 0, 0, 0, 0, 0, 0);

        // 3: tie arbitration from reset alternates RX, TX, RX
        do_reset();
        tx_valid_i = 1'b1; tx_data_i = 8'h77; rx_req_i = 1'b1;
        chk("t3.tie1", 0, 0, 0, 0, 0, 0);
        rx_req_i = 1'b0;
        chk("t3.rx", 0, 0, 1, 0, 0, 0);
        turn2("t3a");
        chk("t3.idle", 0, 0, 0, 0, 0, 0);
        txb("t3.b0", 8'h77, 0);
        tx_valid_i = 1'b0;
        chk("t3.last", 1, 1, 1, 0, 0, 1);
        turn2("t3b");
        tx_valid_i = 1'b1; tx_data_i = 8'h88; rx_req_i = 1'b1;
        chk("t3.tie2", 0, 0, 0, 0, 0, 0);
        rx_req_i = 1'b0;
        chk("t3.rx2", 0, 0, 1, 0, 0, 0);
        turn2("t3c");
        chk("t3.idle2", 0, 0, 0, 0, 0, 0);
        txb("t3.b1", 8'h88, 0);
        tx_valid_i = 1'b0;
        chk("t3.last2", 1, 1, 1, 0, 0, 1);
        turn2("t3d");
        chk("t3.idle3", 0, 0, 0, 0, 0, 0);

        // 4: receive bytes, strobe on the drop cycle, strobe ignored in TURN
        rx_req_i = 1'b1;
        chk("t4.idle", 0, 0, 0, 0, 0, 0);
        bus_strobe_i = 1'b1; data_line_i = 8'hA5; rx_q.push_back(8'hA5);
        chk("t4.s0", 0, 0, 1, 0, 0, 0);
        bus_strobe_i = 1'b0; data_line_i = 8'h5A;
        chk("t4.v0", 0, 0, 1, 1, 0, 0);
        bus_strobe_i = 1'b1; data_line_i = 8'h00; rx_q.push_back(8'h00);
        chk("t4.s1", 0, 0, 1, 0, 0, 0);
        bus_strobe_i = 1'b0; data_line_i = 8'hEE;
        chk("t4.v1", 0, 0, 1, 1, 0, 0);
        rx_req_i = 1'b0; bus_strobe_i = 1'b1; data_line_i = 8'h3C; rx_q.push_back(8'h3C);
        chk("t4.s2", 0, 0, 1, 0, 0, 0);
        data_line_i = 8'h99;
        chk("t4.turn0", 0, 0, 1, 1, 0, 0);
        bus_strobe_i = 1'b0;
        chk("t4.turn1", 0, 0, 1, 0, 0, 0);
        chk("t4.idle2", 0, 0, 0, 0, 0, 0);
        ck("t4.rxd_hold", rx_data_o, 8'h3C);

        // 5: reset in the middle of a burst
        tx_valid_i = 1'b1; tx_data_i = 8'hC1;
        chk("t5.idle", 0, 0, 0, 0, 0, 0);
        txb("t5.b0", 8'hC1, 0);
        tx_data_i = 8'hC2; rst_i = 1'b1;
        chk("t5.rstcyc", 1, 1, 1, 0, 0, 1);
        chk("t5.inrst", 0, 0, 0, 0, 0, 0);
        ck("t5.line", data_line_o, 8'h00);
        rst_i = 1'b0; tx_valid_i = 1'b0;
        chk("t5.after", 0, 0, 0, 0, 0, 0);
        ck("t5.line2", data_line_o, 8'h00);

        // 6: RX phase with no strobes
        rx_req_i = 1'b1;
        chk("t6.idle", 0, 0, 0, 0, 0, 0);
        for (int i = 1; i <= 8; i++) begin
            chk($sformatf("t6.rx%0d", i), 0, 0, 1, 0, 0, 0);
        end
        if (TMO) begin
            rx_req_i = 1'b0;
            chk("t6.err", 0, 0, 1, 0, 1, 0);
            chk("t6.turn1", 0, 0, 1, 0, 0, 0);
        end else begin
            for (int i = 9; i <= 20; i++) begin
                chk($sformatf("t6.rx%0d", i), 0, 0, 1, 0, 0, 0);
            end
            rx_req_i = 1'b0;
            chk("t6.drop", 0, 0, 1, 0, 0, 0);
            turn2("t6");
        end
        chk("t6.idle2", 0, 0, 0, 0, 0, 0);

        ck("txq_left", 8'(tx_q.size()), 8'd0);
        ck("rxq_left", 8'(rx_q.size()), 8'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
